scan_seq_ctrl: RTL

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

---
 rtl/scan_ctrl_pkg.sv | 32 +++
 rtl/scan_phase_cnt.sv | 37 +++
 rtl/scan_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
//==============================================================================
// Module   : scan_ctrl_pkg
// Brief    : Shared state type, default sizing and counter-width helper for
//            the scan sequence controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

package scan_ctrl_pkg;

    localparam int c_DEF_CHAIN_LEN  = 8;
    localparam int c_DEF_CAP_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

    // The capture phase can be longer than the chain on short chains, so the
    // phase counter is sized for whichever phase length is larger.
    function automatic int cnt_width(input int chain_len, input int cap_cycles);
        int max_len;
        max_len = (chain_len > cap_cycles) ? chain_len : cap_cycles;
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_phase_cnt.sv
//==============================================================================
// Module   : scan_phase_cnt
// Brief    : Loadable down-counter with zero flag used to time scan phases.
// Revision : 1.0
//==============================================================================
`default_nettype none

module scan_phase_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/scan_seq_ctrl.sv
//==============================================================================
// Module   : scan_seq_ctrl
// Brief    : Sequences one scan pattern: serial load, functional capture,
//            serial unload, then a one-cycle done pulse with the result.
// Revision : 1.0
//==============================================================================
`default_nettype none

module scan_seq_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN  = c_DEF_CHAIN_LEN,
    parameter int CAP_CYCLES = c_DEF_CAP_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 skip_capture,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 scan_out,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 func_enable,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] result_out
);

    localparam int               c_CNT_W    = cnt_width(CHAIN_LEN, CAP_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LOAD_LEN = c_CNT_W'(CHAIN_LEN);
    localparam logic [c_CNT_W-1:0] c_CAP_LEN  = c_CNT_W'(CAP_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    scan_state_t            r_state;
    logic [CHAIN_LEN-1:0]   r_pattern;
    logic                   r_skip;
    logic [CHAIN_LEN-1:0]   r_unload;

    logic                   w_cnt_load;
    logic [c_CNT_W-1:0]     w_cnt_val;
    logic                   w_cnt_dec;
    logic [c_CNT_W-1:0]     w_cnt;
    logic                   w_cnt_zero;
    logic                   w_last;
    logic [CHAIN_LEN-1:0]   w_unload_next;

    scan_phase_cnt #(
        .WIDTH (c_CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    assign w_last        = (w_cnt == c_ONE);
    assign w_unload_next = {r_unload[CHAIN_LEN-2:0], scan_out};

    // Counter holds the remaining cycles of the current phase; it is reloaded
    // on the final cycle of each phase with the length of the next one.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_LOAD_LEN;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_cnt_load = 1'b1;
                end else if (w_last) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = r_skip ? c_LOAD_LEN : c_CAP_LEN;
                end else begin
                    w_cnt_dec = !w_cnt_zero;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    w_cnt_load = 1'b1;
                end else if (w_last) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_LOAD_LEN;
                end else begin
                    w_cnt_dec = !w_cnt_zero;
                end
            end
            ST_UNLOAD: begin
                if (abort) begin
                    w_cnt_load = 1'b1;
                end else begin
                    w_cnt_dec = !w_cnt_zero;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pattern   <= '0;
            r_skip      <= 1'b0;
            r_unload    <= '0;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
            func_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_out  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_pattern   <= pattern_in;
                        r_skip      <= skip_capture;
                        scan_enable <= 1'b1;
                        scan_in     <= pattern_in[CHAIN_LEN-1];
                        busy        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        scan_enable <= 1'b0;
                        scan_in     <= 1'b0;
                        busy        <= 1'b0;
                    end else if (w_last) begin
                        scan_in <= 1'b0;
                        if (r_skip) begin
                            r_state <= ST_UNLOAD;
                        end else begin
                            r_state     <= ST_CAPTURE;
                            scan_enable <= 1'b0;
                            func_enable <= 1'b1;
                        end
                    end else begin
                        // Pattern register walks left so its MSB feeds the chain next.
                        r_pattern <= {r_pattern[CHAIN_LEN-2:0], 1'b0};
                        scan_in   <= r_pattern[CHAIN_LEN-2];
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        func_enable <= 1'b0;
                        busy        <= 1'b0;
                    end else if (w_last) begin
                        r_state     <= ST_UNLOAD;
                        func_enable <= 1'b0;
                        scan_enable <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    r_unload <= w_unload_next;
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        scan_enable <= 1'b0;
                        busy        <= 1'b0;
                    end else if (w_last) begin
                        r_state     <= ST_DONE;
                        scan_enable <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        result_out  <= w_unload_next;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
